grayscale_roi_capture: RTL

//  Streams RGB pixels of one frame from the input FIFO and converts in-ROI pixels to grayscale.

---
 rtl/gs_roi_pkg.sv | 27 ++
 rtl/gs_convert.sv | 25 ++
 rtl/grayscale_roi_capture.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gs_roi_pkg.sv
// Shared types and constants for the grayscale ROI capture block.
package gs_roi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  // BT.601-style luma weights scaled to 256.
  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  localparam int CFG_W = 16;

  // ROI stored as inclusive bounds so the capture loop only needs compares.
  typedef struct packed {
    logic [CFG_W-1:0] x_lo;
    logic [CFG_W-1:0] x_hi;
    logic [CFG_W-1:0] y_lo;
    logic [CFG_W-1:0] y_hi;
    logic             mode;
  } roi_cfg_t;

endpackage

// File: rtl/gs_convert.sv
// Combinational RGB -> grayscale: mode 0 is the channel average, mode 1 is weighted luma.
module gs_convert
  import gs_roi_pkg::*;
#(
  parameter int CH_BITS = 8
) (
  input  logic                 mode,
  input  logic [3*CH_BITS-1:0] rgb,
  output logic [CH_BITS-1:0]   gray
);

  localparam int SW = CH_BITS + 2;
  localparam int PW = CH_BITS + 8;

  logic [CH_BITS-1:0] r, g, b;
  logic [SW-1:0]      sum3;
  logic [PW-1:0]      luma;

  assign {r, g, b} = rgb;
  assign sum3 = SW'(r) + SW'(g) + SW'(b);
  // Weights sum to 256, so the shifted result always fits in CH_BITS.
  assign luma = PW'(LUMA_R) * PW'(r) + PW'(LUMA_G) * PW'(g) + PW'(LUMA_B) * PW'(b);
  assign gray = mode ? CH_BITS'(luma >> 8) : CH_BITS'(sum3 / SW'(3));

endmodule

// File: rtl/grayscale_roi_capture.sv
// Captures one frame's ROI as packed grayscale into a BRAM, drains the rest of the
// frame, then holds the buffer until the consumer releases it.
module grayscale_roi_capture
  import gs_roi_pkg::*;
#(
  parameter int WIDTH     = 720,
  parameter int HEIGHT    = 540,
  parameter int MAX_ROI_W = 512,
  parameter int MAX_ROI_H = 256,
  parameter int CH_BITS   = 8,
  parameter int ADDR_W    = $clog2(MAX_ROI_W * MAX_ROI_H)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_empty,
  input  logic [3*CH_BITS-1:0]           in_dout,
  output logic                           in_rd_en,
  input  logic [$clog2(WIDTH)-1:0]       roi_x0,
  input  logic [$clog2(HEIGHT)-1:0]      roi_y0,
  input  logic [$clog2(MAX_ROI_W+1)-1:0] roi_w,
  input  logic [$clog2(MAX_ROI_H+1)-1:0] roi_h,
  input  logic                           gs_mode,
  input  logic                           release_roi,
  output logic                           out_wr_en,
  output logic [ADDR_W-1:0]              out_wr_addr,
  output logic [CH_BITS-1:0]             out_wr_data,
  output logic                           roi_done,
  output logic                           cfg_err
);

  localparam logic [CFG_W-1:0] X_LAST = CFG_W'(WIDTH - 1);
  localparam logic [CFG_W-1:0] Y_LAST = CFG_W'(HEIGHT - 1);

  state_t             state, state_next;
  roi_cfg_t           cfg, cfg_in;
  logic               cfg_ok, cfg_bad, rel_seen;
  logic [CFG_W-1:0]   x, y;
  logic [ADDR_W-1:0]  addr;
  logic [CH_BITS-1:0] gray;
  logic               in_roi, roi_last, frame_last;
  logic               wr, latch_cfg, err_pulse;

  gs_convert #(.CH_BITS(CH_BITS)) u_convert (
    .mode (cfg.mode),
    .rgb  (in_dout),
    .gray (gray)
  );

  assign cfg_in.x_lo = CFG_W'(roi_x0);
  assign cfg_in.x_hi = CFG_W'(roi_x0) + CFG_W'(roi_w) - CFG_W'(1);
  assign cfg_in.y_lo = CFG_W'(roi_y0);
  assign cfg_in.y_hi = CFG_W'(roi_y0) + CFG_W'(roi_h) - CFG_W'(1);
  assign cfg_in.mode = gs_mode;

  assign cfg_ok = (roi_w != '0) && (roi_h != '0)
               && (CFG_W'(roi_w) <= CFG_W'(MAX_ROI_W))
               && (CFG_W'(roi_h) <= CFG_W'(MAX_ROI_H))
               && (CFG_W'(roi_x0) + CFG_W'(roi_w) <= CFG_W'(WIDTH))
               && (CFG_W'(roi_y0) + CFG_W'(roi_h) <= CFG_W'(HEIGHT));

  assign in_roi     = (x >= cfg.x_lo) && (x <= cfg.x_hi) && (y >= cfg.y_lo) && (y <= cfg.y_hi);
  assign roi_last   = (x == cfg.x_hi) && (y == cfg.y_hi);
  assign frame_last = (x == X_LAST) && (y == Y_LAST);
  assign roi_done   = (state == ST_HOLD) && !cfg_bad;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_next = state;
    in_rd_en   = 1'b0;
    wr         = 1'b0;
    latch_cfg  = 1'b0;
    err_pulse  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!in_empty) begin
          latch_cfg = 1'b1;
          if (cfg_ok) begin
            state_next = ST_CAPTURE;
          end else begin
            err_pulse  = 1'b1;
            state_next = ST_DRAIN;
          end
        end
      end
      ST_CAPTURE: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          if (in_roi) begin
            wr = 1'b1;
            if (roi_last) state_next = frame_last ? ST_HOLD : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          if (frame_last) state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cfg_bad || release_roi || rel_seen) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cfg         <= '0;
      cfg_bad     <= 1'b0;
      rel_seen    <= 1'b0;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state     <= state_next;
      cfg_err   <= err_pulse;
      out_wr_en <= wr;
      if (wr) begin
        out_wr_addr <= addr;
        out_wr_data <= gray;
      end
      if (latch_cfg) begin
        cfg     <= cfg_in;
        cfg_bad <= !cfg_ok;
        x       <= '0;
        y       <= '0;
        addr    <= '0;
      end else if (in_rd_en) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= y + CFG_W'(1);
        end else begin
          x <= x + CFG_W'(1);
        end
        if (wr) addr <= addr + ADDR_W'(1);
      end
      // An early release seen while draining is remembered until HOLD consumes it.
      if (state == ST_DRAIN && release_roi) rel_seen <= 1'b1;
      else if (state == ST_HOLD && state_next == ST_IDLE) rel_seen <= 1'b0;
    end
  end

endmodule
